rvfpm_issue_queue: RTL and testbench

RVFPM_ISSUE_QUEUE -- requirements
Module: rvfpm_issue_queue

---
 rtl/rvfpm_pkg.sv | 23 ++
 rtl/rvfpm_fp_decode.sv | 21 ++
 rtl/rvfpm_issue_queue.sv | 110 +++++++++++
 tb/tb_rvfpm_issue_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rvfpm_pkg.sv
// Shared opcode constants and the issue-queue entry record.
// Entry fields are sized for the widest supported configuration (X_ID_WIDTH <= 16, XLEN <= 64).
package rvfpm_pkg;

    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;  // FLW
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;  // FSW
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_FMADD    = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD   = 7'b1001111;

    localparam int ENTRY_ID_W = 16;
    localparam int ENTRY_XLEN = 64;

    typedef struct packed {
        logic [31:0]             instruction;
        logic [ENTRY_ID_W-1:0]   id;
        logic [ENTRY_XLEN-1:0]   data_fromXreg;
        logic [ENTRY_XLEN-1:0]   data_fromMem;
    } entry_t;

endpackage

// File: rtl/rvfpm_fp_decode.sv
// Flags RISC-V instruction words whose major opcode belongs to the F extension.
module rvfpm_fp_decode
    import rvfpm_pkg::*;
(
    input  logic [31:0] instruction,
    output logic        is_fp
);

    logic [6:0] opcode;
    assign opcode = instruction[6:0];

    always_comb begin
        is_fp = 1'b0;
        case (opcode)
            OPC_LOAD_FP, OPC_STORE_FP, OPC_OP_FP,
            OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: is_fp = 1'b1;
            default:                                      is_fp = 1'b0;
        endcase
    end

endmodule

// File: rtl/rvfpm_issue_queue.sv
// In-order FIFO between the core and the FPU; non-FP words are dropped and reported.
// Optional same-cycle bypass into an empty queue: define RVFPM_ISSUE_BYPASS_EN.
module rvfpm_issue_queue
    import rvfpm_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4,
    parameter int XLEN       = 32
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instruction,
    input  logic [X_ID_WIDTH-1:0] in_id,
    input  logic [XLEN-1:0]       in_data_fromXreg,
    input  logic [XLEN-1:0]       in_data_fromMem,
    output logic                  fpu_enable,
    input  logic                  fpu_stall,
    output logic [31:0]           fpu_instruction,
    output logic [X_ID_WIDTH-1:0] fpu_id,
    output logic [XLEN-1:0]       fpu_data_fromXreg,
    output logic [XLEN-1:0]       fpu_data_fromMem,
    output logic                  reject_valid,
    output logic [X_ID_WIDTH-1:0] reject_id
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t                mem_q [DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  reject_valid_q, reject_valid_d;
    logic [X_ID_WIDTH-1:0] reject_id_q, reject_id_d;

    logic   is_fp, empty, full, accept, bypass, push, pop;
    entry_t in_entry, head;

    rvfpm_fp_decode u_decode (
        .instruction (in_instruction),
        .is_fp       (is_fp)
    );

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign accept = in_valid && in_ready;

`ifdef RVFPM_ISSUE_BYPASS_EN
    assign bypass = accept && is_fp && empty && !fpu_stall;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word is consumed directly, so it is neither stored nor popped.
    assign push = accept && is_fp && !bypass;
    assign pop  = !empty && !fpu_stall;

    always_comb begin
        in_entry               = '0;
        in_entry.instruction   = in_instruction;
        in_entry.id            = ENTRY_ID_W'(in_id);
        in_entry.data_fromXreg = ENTRY_XLEN'(in_data_fromXreg);
        in_entry.data_fromMem  = ENTRY_XLEN'(in_data_fromMem);
    end

    always_comb begin
        head = '0;
        if (bypass)      head = in_entry;
        else if (!empty) head = mem_q[rptr_q];
    end

    assign in_ready          = !full;
    assign fpu_enable        = !empty || bypass;
    assign fpu_instruction   = head.instruction;
    assign fpu_id            = X_ID_WIDTH'(head.id);
    assign fpu_data_fromXreg = XLEN'(head.data_fromXreg);
    assign fpu_data_fromMem  = XLEN'(head.data_fromMem);
    assign reject_valid      = reject_valid_q;
    assign reject_id         = reject_id_q;

    always_comb begin
        wptr_d         = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d         = pop  ? rptr_q + 1'b1 : rptr_q;
        cnt_d          = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
        reject_valid_d = accept && !is_fp;
        reject_id_d    = reject_valid_d ? in_id : reject_id_q;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            cnt_q          <= '0;
            reject_valid_q <= 1'b0;
            reject_id_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            cnt_q          <= cnt_d;
            reject_valid_q <= reject_valid_d;
            reject_id_q    <= reject_id_d;
            if (push) mem_q[wptr_q] <= in_entry;
        end
    end

endmodule

// File: tb/tb_rvfpm_issue_queue.sv
// Directed self-checking bench for rvfpm_issue_queue (DEPTH=4, X_ID_WIDTH=4, XLEN=32).
module tb_rvfpm_issue_queue;

    logic        ck = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [3:0]  in_id;
    logic [31:0] in_data_fromXreg;
    logic [31:0] in_data_fromMem;
    logic        fpu_enable;
    logic        fpu_stall;
    logic [31:0] fpu_instruction;
    logic [3:0]  fpu_id;
    logic [31:0] fpu_data_fromXreg;
    logic [31:0] fpu_data_fromMem;
    logic        reject_valid;
    logic [3:0]  reject_id;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] FLW1  = 32'h0040_2087;
    localparam logic [31:0] FADD  = 32'h0020_81d3;
    localparam logic [31:0] FSW   = 32'h0000_a027;
    localparam logic [31:0] ILOAD = 32'h0040_2083;

    rvfpm_issue_queue #(.DEPTH(4), .X_ID_WIDTH(4), .XLEN(32)) dut (
        .ck                (ck),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_instruction    (in_instruction),
        .in_id             (in_id),
        .in_data_fromXreg  (in_data_fromXreg),
        .in_data_fromMem   (in_data_fromMem),
        .fpu_enable        (fpu_enable),
        .fpu_stall         (fpu_stall),
        .fpu_instruction   (fpu_instruction),
        .fpu_id            (fpu_id),
        .fpu_data_fromXreg (fpu_data_fromXreg),
        .fpu_data_fromMem  (fpu_data_fromMem),
        .reject_valid      (reject_valid),
        .reject_id         (reject_id)
    );

    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [3:0] id,
                         input logic [31:0] xr, input logic [31:0] mem);
        in_valid         = 1'b1;
        in_instruction   = ins;
        in_id            = id;
        in_data_fromXreg = xr;
        in_data_fromMem  = mem;
    endtask

    task automatic idle();
        in_valid         = 1'b0;
        in_instruction   = '0;
        in_id            = '0;
        in_data_fromXreg = '0;
        in_data_fromMem  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fpu_stall = 1'b0; idle();
        step(); step();
        rst = 1'b0;
        #1;
        n_checks++; if (fpu_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got %0b want 0", fpu_enable); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", in_ready); end
        n_checks++; if (fpu_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", fpu_instruction); end
        n_checks++; if (reject_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rejv got %0b want 0", reject_valid); end
        n_checks++; if (reject_id !== 4'h0) begin n_fail++; $display("FAIL reset_rejid got %h want 0", reject_id); end
    endtask

    task automatic test_single_flw();
        drive(FLW1, 4'd1, 32'h1000_0000, 32'h3f80_0000);
        #1;
`ifdef RVFPM_ISSUE_BYPASS_EN
        n_checks++; if (fpu_enable !== 1'b1) begin n_fail++; $display("FAIL flw_same_cycle got %0b want 1", fpu_enable); end
        step(); idle(); #1;
        n_checks++; if (fpu_enable !== 1'b0) begin n_fail++; $display("FAIL flw_bypass_no_store got %0b want 0", fpu_enable); end
`else
        n_checks++; if (fpu_enable !== 1'b0) begin n_fail++; $display("FAIL flw_same_cycle got %0b want 0", fpu_enable); end
        step(); idle(); #1;
        n_checks++; if (fpu_enable !== 1'b1) begin n_fail++; $display("FAIL flw_enable got %0b want 1", fpu_enable); end
        n_checks++; if (fpu_id !== 4'd1) begin n_fail++; $display("FAIL flw_id got %0d want 1", fpu_id); end
        n_checks++; if (fpu_data_fromMem !== 32'h3f80_0000) begin n_fail++; $display("FAIL flw_mem got %h want 3f800000", fpu_data_fromMem); end
        n_checks++; if (fpu_data_fromXreg !== 32'h1000_0000) begin n_fail++; $display("FAIL flw_xreg got %h want 10000000", fpu_data_fromXreg); end
        n_checks++; if (fpu_instruction !== FLW1) begin n_fail++; $display("FAIL flw_instr got %h want %h", fpu_instruction, FLW1); end
        step();
        n_checks++; if (fpu_enable !== 1'b0) begin n_fail++; $display("FAIL flw_popped got %0b want 0", fpu_enable); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4];
        logic [3:0]  ids [4];
        logic [31:0] mems[4];
        ins[0] = FLW1; ins[1] = FLW1;  ins[2] = FADD; ins[3] = FSW;
        ids[0] = 4'd2; ids[1] = 4'd3;  ids[2] = 4'd4; ids[3] = 4'd6;
        mems[0] = 32'h3f80_0000; mems[1] = 32'h4120_28f6; mems[2] = 32'h0; mems[3] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(ins[i], ids[i], 32'h0, mems[i]);
            else       idle();
            #1;
`ifdef RVFPM_ISSUE_BYPASS_EN
            if (i < 4) begin
                n_checks++; if (fpu_id !== ids[i]) begin n_fail++; $display("FAIL b2b_id[%0d] got %0d want %0d", i, fpu_id, ids[i]); end
            end
`else
            if (i > 0) begin
                n_checks++; if (fpu_enable !== 1'b1) begin n_fail++; $display("FAIL b2b_enable[%0d] got %0b want 1", i, fpu_enable); end
                n_checks++; if (fpu_id !== ids[i-1]) begin n_fail++; $display("FAIL b2b_id[%0d] got %0d want %0d", i, fpu_id, ids[i-1]); end
                n_checks++; if (fpu_instruction !== ins[i-1]) begin n_fail++; $display("FAIL b2b_instr[%0d] got %h want %h", i, fpu_instruction, ins[i-1]); end
                n_checks++; if (fpu_data_fromMem !== mems[i-1]) begin n_fail++; $display("FAIL b2b_mem[%0d] got %h want %h", i, fpu_data_fromMem, mems[i-1]); end
            end
`endif
            step();
        end
        n_checks++; if (fpu_enable !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got %0b want 0", fpu_enable); end
    endtask

    task automatic test_full_stall();
        fpu_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(FADD, 4'(k + 8), 32'(k), 32'h0);
            #1;
            n_checks++; if (in_ready !== (k < 4)) begin n_fail++; $display("FAIL full_ready[%0d] got %0b want %0b", k, in_ready, (k < 4)); end
            step();
        end
        idle(); #1;
        n_checks++; if (fpu_id !== 4'd8) begin n_fail++; $display("FAIL full_head got %0d want 8", fpu_id); end
        fpu_stall = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            n_checks++; if (fpu_id !== 4'(j + 8)) begin n_fail++; $display("FAIL full_pop_id[%0d] got %0d want %0d", j, fpu_id, j + 8); end
            n_checks++; if (fpu_data_fromXreg !== 32'(j)) begin n_fail++; $display("FAIL full_pop_x[%0d] got %h want %h", j, fpu_data_fromXreg, j); end
            step();
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back[%0d] got %0b want 1", j, in_ready); end
        end
        n_checks++; if (fpu_enable !== 1'b0) begin n_fail++; $display("FAIL full_drained got %0b want 0", fpu_enable); end
    endtask

    task automatic test_reject();
        drive(ILOAD, 4'd5, 32'h0, 32'h1234_5678);
        step(); idle(); #1;
        n_checks++; if (reject_valid !== 1'b1) begin n_fail++; $display("FAIL rej_valid got %0b want 1", reject_valid); end
        n_checks++; if (reject_id !== 4'd5) begin n_fail++; $display("FAIL rej_id got %0d want 5", reject_id); end
        n_checks++; if (fpu_enable !== 1'b0) begin n_fail++; $display("FAIL rej_no_enq got %0b want 0", fpu_enable); end
        step();
        n_checks++; if (reject_valid !== 1'b0) begin n_fail++; $display("FAIL rej_pulse got %0b want 0", reject_valid); end
        n_checks++; if (reject_id !== 4'd5) begin n_fail++; $display("FAIL rej_hold got %0d want 5", reject_id); end
    endtask

    task automatic test_empty_stall();
        fpu_stall = 1'b1; idle();
        step();
        n_checks++; if (fpu_enable !== 1'b0) begin n_fail++; $display("FAIL empty_stall_en got %0b want 0", fpu_enable); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL empty_stall_rdy got %0b want 1", in_ready); end
        fpu_stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        fpu_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(FLW1, 4'(k + 1), 32'hdead_0000, 32'hbeef_0000);
            step();
        end
        #1;
        n_checks++; if (fpu_enable !== 1'b1) begin n_fail++; $display("FAIL mid_pre_en got %0b want 1", fpu_enable); end
        rst = 1'b1; fpu_stall = 1'b0;
        step();
        rst = 1'b0; idle(); #1;
        n_checks++; if (fpu_enable !== 1'b0) begin n_fail++; $display("FAIL mid_en got %0b want 0", fpu_enable); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %0b want 1", in_ready); end
        n_checks++; if (fpu_instruction !== 32'h0) begin n_fail++; $display("FAIL mid_instr got %h want 0", fpu_instruction); end
        n_checks++; if (fpu_id !== 4'h0) begin n_fail++; $display("FAIL mid_id got %h want 0", fpu_id); end
        n_checks++; if (fpu_data_fromMem !== 32'h0) begin n_fail++; $display("FAIL mid_mem got %h want 0", fpu_data_fromMem); end
        n_checks++; if (fpu_data_fromXreg !== 32'h0) begin n_fail++; $display("FAIL mid_xreg got %h want 0", fpu_data_fromXreg); end
        step();
        n_checks++; if (fpu_enable !== 1'b0) begin n_fail++; $display("FAIL mid_stays_empty got %0b want 0", fpu_enable); end
    endtask

    initial begin
        test_reset();
        test_single_flw();
        test_back_to_back();
        test_full_stall();
        test_reject();
        test_empty_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
